bit_scan_unit: RTL

Parametrised, multi-cycle bit-position encoder for the processor datapath's bit-scan instructions. It returns the 1-based position of the lowest or highest set bit of a WIDTH-bit operand, or WIDTH+1 when the operand is zero. It examines CHUNK bits per cycle and terminates early on the first hit. It sits beside the ALU behind a valid/ready handshake, so the control unit can stall on it.

---
 rtl/bit_scan_unit.sv | 116 +++++++++++
 1 files changed

// File: rtl/bit_scan_unit.sv
// Multi-cycle lowest/highest set-bit encoder: scans CHUNK bits per cycle with
// early exit, returning a 1-based position or WIDTH+1 for a zero operand.
module bit_scan_unit #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8,
   parameter int RES_W = $clog2(WIDTH+2)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [RES_W-1:0] out_idx,
   output logic             out_zero
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int K_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int P_W    = (CHUNK > 1) ? $clog2(CHUNK) : 1;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   sreg_q, sreg_d;
   logic               mode_q, mode_d;
   logic [K_W-1:0]     k_q, k_d;
   logic [RES_W-1:0]   idx_q, idx_d;
   logic               zero_q, zero_d;

   logic [WIDTH-1:0]   in_rev;
   logic [CHUNK-1:0]   chunk;
   logic               hit;
   logic [P_W-1:0]     p;
   logic [RES_W-1:0]   pos;

   // Highest-bit search reuses the lowest-bit datapath on a mirrored operand.
   always_comb begin
      in_rev = '0;
      for (int i = 0; i < WIDTH; i++) in_rev[i] = in_data[WIDTH-1-i];
   end

   always_comb begin
      chunk = sreg_q[CHUNK-1:0];
      hit   = |chunk;
      p     = '0;
      for (int i = CHUNK-1; i >= 0; i--) begin
         if (chunk[i]) p = P_W'(i);
      end
      pos = RES_W'(k_q) * RES_W'(CHUNK) + RES_W'(p);
   end

   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      mode_d  = mode_q;
      k_d     = k_q;
      idx_d   = idx_q;
      zero_d  = zero_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               sreg_d  = in_mode ? in_rev : in_data;
               mode_d  = in_mode;
               k_d     = '0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (hit) begin
               idx_d   = mode_q ? (RES_W'(WIDTH) - pos) : (pos + RES_W'(1));
               zero_d  = 1'b0;
               state_d = DONE;
            end else if (k_q == K_W'(NCHUNK-1)) begin
               idx_d   = RES_W'(WIDTH+1);
               zero_d  = 1'b1;
               state_d = DONE;
            end else begin
               sreg_d = sreg_q >> CHUNK;
               k_d    = k_q + K_W'(1);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         mode_q  <= 1'b0;
         k_q     <= '0;
         idx_q   <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         mode_q  <= mode_d;
         k_q     <= k_d;
         idx_q   <= idx_d;
         zero_q  <= zero_d;
      end
   end

   // Handshakes are masked while reset is held so nothing is offered or accepted.
   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == DONE) && !rst;
   assign out_idx   = idx_q;
   assign out_zero  = zero_q;

endmodule
